dmul_rot_seq_ctrl: RTL and testbench

- Sequencing controller for one rotated-LFSR unary stochastic multiplier instance.
- Accepts operand pairs over a valid/ready handshake and drives the multiplier's operand, seed and load pins.
- Times the full joint-LFSR accumulation window, then captures the multiplier's count and presents it over a valid/ready output handshake.
- Sits between an operand producer (DMA/testbench) and the dMUL datapath.

---
 rtl/dmul_rot_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmul_rot_seq_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmul_rot_seq_ctrl.sv
// ============================================================================
//  Module   : dmul_rot_seq_ctrl
//  Purpose  : Sequencing controller for one rotated-LFSR unary stochastic
//             multiplier. Accepts operand pairs (valid/ready), pulses the
//             multiplier load pins, times the joint-LFSR accumulation window,
//             captures the multiplier count and offers it on a valid/ready
//             output. Optional feature macro: DMUL_SEQ_CTRL_EARLY_TERM_EN
//             (per-operation run length via in_len, 0 selects RUN_LEN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmul_rot_seq_ctrl #(
    parameter int                DATAWD  = 8,
    parameter logic [DATAWD-1:0] SEED_A  = 'h01,
    parameter logic [DATAWD-1:0] SEED_B  = 'h01,
    parameter logic [DATAWD-1:0] SEED_U  = 'h01,
    parameter int                RUN_LEN = ((1 << DATAWD) - 1) * ((1 << DATAWD) - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATAWD-1:0]     in_a,
    input  logic [DATAWD-1:0]     in_b,
`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
    input  logic [2*DATAWD-1:0]   in_len,
`endif
    input  logic                  flush,
    output logic [DATAWD-1:0]     mul_iA,
    output logic [DATAWD-1:0]     mul_iB,
    output logic                  mul_loadA,
    output logic                  mul_loadB,
    output logic [DATAWD-1:0]     mul_seedA,
    output logic [DATAWD-1:0]     mul_seedB,
    output logic [DATAWD-1:0]     mul_seedU,
    input  logic [2*DATAWD-1:0]   mul_oC,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATAWD-1:0]   out_c,
    output logic                  busy
);

    // Counter value loaded in LOAD so that RUN spans exactly RUN_LEN cycles
    // (counts RUN_LEN-1 down to 0 inclusive).
    localparam logic [2*DATAWD-1:0] c_run_last = (2*DATAWD)'(RUN_LEN - 1);

    // A zero-length run would never capture; an oversized one cannot be counted.
    if ((RUN_LEN < 1) || (longint'(RUN_LEN) > (longint'(1) << (2*DATAWD)))) begin : g_bad_run_len
        $error("dmul_rot_seq_ctrl: RUN_LEN must be in 1 .. 2**(2*DATAWD)");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [2*DATAWD-1:0]   r_cnt;
    logic [DATAWD-1:0]     r_op_a;
    logic [DATAWD-1:0]     r_op_b;
    logic [2*DATAWD-1:0]   r_out_c;
    logic [2*DATAWD-1:0]   w_cnt_start;
    logic                  w_accept;

    // Flush outranks a new operand in IDLE.
    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;

`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
    logic [2*DATAWD-1:0]   r_len;

    // Run length travels with the operands; zero selects the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= in_len;
        end
    end

    assign w_cnt_start = (r_len == '0) ? c_run_last : (r_len - 1'b1);
`else
    assign w_cnt_start = c_run_last;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid && !flush) w_next_state = ST_LOAD;
            ST_LOAD:    w_next_state = ST_RUN;
            ST_RUN:     if (r_cnt == '0) w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_OUT;
            ST_OUT:     if (out_ready) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
        if (flush) begin
            w_next_state = ST_IDLE;
        end
    end

    // Operand registers: only written on acceptance so the multiplier sees
    // stable operands for the whole accumulation window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_accept) begin
            r_op_a <= in_a;
            r_op_b <= in_b;
        end
    end

    // Run counter: armed in LOAD, counts down through RUN, parked at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cnt <= w_cnt_start;
        end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result capture; a flush in CAPTURE discards the result and keeps the
    // previous out_c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_c <= '0;
        end else if ((r_state == ST_CAPTURE) && !flush) begin
            r_out_c <= mul_oC;
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_OUT);
    assign out_c     = r_out_c;
    assign mul_iA    = r_op_a;
    assign mul_iB    = r_op_b;
    assign mul_loadA = (r_state == ST_LOAD);
    assign mul_loadB = (r_state == ST_LOAD);
    assign mul_seedA = SEED_A;
    assign mul_seedB = SEED_B;
    assign mul_seedU = SEED_U;

endmodule

`default_nettype wire

// File: tb/tb_dmul_rot_seq_ctrl.sv
// ============================================================================
//  Module   : tb_dmul_rot_seq_ctrl
//  Purpose  : Self-checking bench for dmul_rot_seq_ctrl at DATAWD=3
//             (RUN_LEN=49). A behavioural unary multiplier drives mul_oC so
//             that a full window yields exactly a*b; optional stub value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmul_rot_seq_ctrl;

    localparam int DW = 3;
    localparam int P  = 7;
    localparam int RL = 49;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
    logic [2*DW-1:0] in_len;
`endif
    logic          flush;
    logic [DW-1:0] mul_iA, mul_iB, mul_seedA, mul_seedB, mul_seedU;
    logic          mul_loadA, mul_loadB;
    logic [2*DW-1:0] mul_oC;
    logic          out_valid;
    logic          out_ready;
    logic [2*DW-1:0] out_c;
    logic          busy;

    int            vecs = 0;
    int            miss = 0;
    logic [2*DW-1:0] exp_last;

    // Behavioural multiplier: cycle k of the window counts when the A stream
    // (k mod P) and B stream (k div P) are both below their operands.
    logic            stub_en;
    logic [2*DW-1:0] stub_val;
    logic [2*DW-1:0] acc;
    int              k;

    always @(posedge clk) begin
        if (mul_loadA) begin
            acc <= '0;
            k   <= 0;
        end else begin
            if (((k % P) < int'(mul_iA)) && (((k / P) % P) < int'(mul_iB)))
                acc <= acc + 1'b1;
            k <= k + 1;
        end
    end

    assign mul_oC = stub_en ? stub_val : acc;

    always #5 clk = ~clk;

    dmul_rot_seq_ctrl #(
        .DATAWD (DW),
        .SEED_A (3'h1),
        .SEED_B (3'h1),
        .SEED_U (3'h1),
        .RUN_LEN(RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
        .in_len   (in_len),
`endif
        .flush    (flush),
        .mul_iA   (mul_iA),
        .mul_iB   (mul_iB),
        .mul_loadA(mul_loadA),
        .mul_loadB(mul_loadB),
        .mul_seedA(mul_seedA),
        .mul_seedB(mul_seedB),
        .mul_seedU(mul_seedU),
        .mul_oC   (mul_oC),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_c    (out_c),
        .busy     (busy)
    );

    // Reference: number of joint-stream hits in the first len cycles.
    function automatic logic [2*DW-1:0] model(input int a, input int b, input int len);
        int cnt = 0;
        for (int i = 0; i < len; i++)
            if ((i % P) < a && ((i / P) % P) < b) cnt++;
        return (2*DW)'(cnt);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step;
        in_valid = 1'b0;
    endtask

    // Advance until out_valid, counting edges since acceptance (bounded).
    task automatic run_to_valid(inout int n);
        while (!out_valid && n < RL + 20) begin
            step;
            n++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; flush = 1'b0;
        out_ready = 1'b0; stub_en = 1'b0; stub_val = '0;
`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
        in_len = '0;
`endif
        step; step;
        vecs++;
        if (in_ready !== 1'b0) begin
            miss++; $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        vecs++;
        if ({in_ready, out_valid, busy, mul_loadA, mul_loadB} !== 5'b10000) begin
            miss++; $display("FAIL reset_ctrl: got %b expected 10000",
                             {in_ready, out_valid, busy, mul_loadA, mul_loadB});
        end
        vecs++;
        if ({out_c, mul_iA, mul_iB} !== '0) begin
            miss++; $display("FAIL reset_data: got %h expected 0", {out_c, mul_iA, mul_iB});
        end
        vecs++;
        if ({mul_seedA, mul_seedB, mul_seedU} !== 9'b001_001_001) begin
            miss++; $display("FAIL reset_seeds: got %b expected 001001001",
                             {mul_seedA, mul_seedB, mul_seedU});
        end
    endtask

    task automatic test_single_stub;
        int n;
        stub_en = 1'b1; stub_val = 6'h34;
        accept(3'd3, 3'd5);
        n = 0;
        vecs++;
        if ({mul_loadA, mul_loadB, busy, in_ready} !== 4'b1110) begin
            miss++; $display("FAIL stub_load_pulse: got %b expected 1110",
                             {mul_loadA, mul_loadB, busy, in_ready});
        end
        vecs++;
        if ({mul_iA, mul_iB} !== {3'd3, 3'd5}) begin
            miss++; $display("FAIL stub_operands: got %h expected %h", {mul_iA, mul_iB}, {3'd3, 3'd5});
        end
        step; n = 1;
        vecs++;
        if ({mul_loadA, mul_loadB} !== 2'b00) begin
            miss++; $display("FAIL stub_load_width: got %b expected 00", {mul_loadA, mul_loadB});
        end
        run_to_valid(n);
        vecs++;
        if (n !== RL + 2) begin
            miss++; $display("FAIL stub_latency: got %0d expected %0d", n, RL + 2);
        end
        vecs++;
        if (out_c !== 6'h34) begin
            miss++; $display("FAIL stub_out_c: got %h expected 34", out_c);
        end
        handshake;
        vecs++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miss++; $display("FAIL stub_after_hs: got %b expected 01", {out_valid, in_ready});
        end
        exp_last = 6'h34;
        stub_en = 1'b0;
    endtask

    task automatic test_products;
        int n;
        logic [DW-1:0] a, b;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) begin
                a = 3'd0; b = 3'd7;
            end else begin
                a = DW'($urandom_range(0, 7));
                b = DW'($urandom_range(0, 7));
            end
            accept(a, b);
            n = 0;
            run_to_valid(n);
            vecs++;
            if (n !== RL + 2) begin
                miss++; $display("FAIL prod_latency[%0d]: got %0d expected %0d", t, n, RL + 2);
            end
            exp_last = model(int'(a), int'(b), RL);
            vecs++;
            if (out_c !== exp_last) begin
                miss++; $display("FAIL prod_value[%0d] a=%0d b=%0d: got %0d expected %0d",
                                 t, a, b, out_c, exp_last);
            end
            for (int d = $urandom_range(0, 3); d > 0; d--) begin
                step;
                vecs++;
                if ({out_valid, out_c} !== {1'b1, exp_last}) begin
                    miss++; $display("FAIL prod_hold[%0d]: got %b/%0d expected 1/%0d",
                                     t, out_valid, out_c, exp_last);
                end
            end
            handshake;
        end
    endtask

    task automatic test_backpressure;
        int n;
        accept(3'd5, 3'd6);
        n = 0;
        run_to_valid(n);
        exp_last = model(5, 6, RL);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_a = 3'd1; in_b = 3'd1;
            step;
            vecs++;
            if ({out_valid, in_ready, out_c, mul_iA, mul_iB} !== {2'b10, exp_last, 3'd5, 3'd6}) begin
                miss++; $display("FAIL backpressure[%0d]: got v=%b r=%b c=%0d a=%0d b=%0d expected v=1 r=0 c=%0d a=5 b=6",
                                 i, out_valid, in_ready, out_c, mul_iA, mul_iB, exp_last);
            end
        end
        in_valid = 1'b0;
        handshake;
    endtask

    task automatic test_back_to_back;
        int cycle = 0, nacc = 0, nld = 0, hs = -1;
        int acc_cyc[2];
        logic [DW-1:0] ld_a[2];
        in_valid = 1'b1; in_a = 3'd2; in_b = 3'd3; out_ready = 1'b1;
        while ((nacc < 2 || nld < 2) && cycle < 3 * RL) begin
            if (in_valid && in_ready && nacc < 2) begin
                acc_cyc[nacc] = cycle; nacc++;
            end
            if (out_valid && hs < 0) begin
                hs = cycle;
                vecs++;
                if (out_c !== model(2, 3, RL)) begin
                    miss++; $display("FAIL b2b_first_value: got %0d expected %0d", out_c, model(2, 3, RL));
                end
            end
            if (mul_loadA && nld < 2) begin
                ld_a[nld] = mul_iA; nld++;
            end
            step;
            cycle++;
            if (nacc == 1) begin
                in_a = 3'd6; in_b = 3'd5;
            end
        end
        in_valid = 1'b0;
        vecs++;
        if (nacc !== 2 || nld !== 2 || hs < 0) begin
            miss++; $display("FAIL b2b_events: got acc=%0d loads=%0d hs=%0d expected 2/2/>=0", nacc, nld, hs);
        end else begin
            vecs++;
            if (acc_cyc[1] - hs !== 1) begin
                miss++; $display("FAIL b2b_gap: got %0d expected 1", acc_cyc[1] - hs);
            end
            vecs++;
            if ({ld_a[0], ld_a[1]} !== {3'd2, 3'd6}) begin
                miss++; $display("FAIL b2b_loads: got %0d,%0d expected 2,6", ld_a[0], ld_a[1]);
            end
        end
        cycle = 0;
        while (!out_valid && cycle < RL + 20) begin
            step; cycle++;
        end
        exp_last = model(6, 5, RL);
        vecs++;
        if ({out_valid, out_c} !== {1'b1, exp_last}) begin
            miss++; $display("FAIL b2b_second_value: got %b/%0d expected 1/%0d", out_valid, out_c, exp_last);
        end
        step;
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        logic seen = 1'b0;
        accept(3'd4, 3'd4);
        for (int i = 0; i < 10; i++) step;
        flush = 1'b1;
        step;
        flush = 1'b0;
        vecs++;
        if ({busy, in_ready, out_valid, out_c} !== {3'b010, exp_last}) begin
            miss++; $display("FAIL flush_run: got b=%b r=%b v=%b c=%0d expected 0/1/0/%0d",
                             busy, in_ready, out_valid, out_c, exp_last);
        end
        for (int i = 0; i < RL + 10; i++) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            miss++; $display("FAIL flush_no_output: got 1 expected 0");
        end
        in_valid = 1'b1; flush = 1'b1; in_a = 3'd7;
        step;
        in_valid = 1'b0; flush = 1'b0;
        vecs++;
        if ({busy, mul_iA} !== {1'b0, 3'd4}) begin
            miss++; $display("FAIL flush_idle_accept: got b=%b a=%0d expected 0/4", busy, mul_iA);
        end
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        int n;
        accept(3'd7, 3'd7);
        for (int i = 0; i < 10; i++) step;
        rst = 1'b1;
        #1;
        vecs++;
        if ({busy, in_ready, out_valid, out_c, mul_iA} !== '0) begin
            miss++; $display("FAIL rst_mid: got b=%b r=%b v=%b c=%0d a=%0d expected all 0",
                             busy, in_ready, out_valid, out_c, mul_iA);
        end
        step;
        rst = 1'b0;
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            miss++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < RL + 10; i++) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            miss++; $display("FAIL rst_mid_no_output: got 1 expected 0");
        end
        accept(3'd3, 3'd3);
        n = 0;
        run_to_valid(n);
        exp_last = model(3, 3, RL);
        vecs++;
        if ({n, out_c} !== {RL + 2, exp_last}) begin
            miss++; $display("FAIL rst_recover: got n=%0d c=%0d expected %0d/%0d", n, out_c, RL + 2, exp_last);
        end
        handshake;
    endtask

`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
    task automatic test_early_term;
        int n;
        in_len = 6'd5;
        accept(3'd7, 3'd7);
        n = 0;
        run_to_valid(n);
        vecs++;
        if ({n, out_c} !== {32'd7, model(7, 7, 5)}) begin
            miss++; $display("FAIL early_len5: got n=%0d c=%0d expected 7/%0d", n, out_c, model(7, 7, 5));
        end
        handshake;
        in_len = 6'd0;
        accept(3'd2, 3'd3);
        n = 0;
        run_to_valid(n);
        vecs++;
        if ({n, out_c} !== {RL + 2, model(2, 3, RL)}) begin
            miss++; $display("FAIL early_len0: got n=%0d c=%0d expected %0d/%0d", n, out_c, RL + 2, model(2, 3, RL));
        end
        handshake;
    endtask
`endif

    initial begin
        test_reset;
        test_single_stub;
        test_products;
        test_backpressure;
        test_back_to_back;
        test_flush;
        test_reset_mid;
`ifdef DMUL_SEQ_CTRL_EARLY_TERM_EN
        test_early_term;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
